// File: rtl/aes128_pkg.sv
// aes128_pkg: shared FSM states, round constants and forward S-box for the AES-128 decipher controller.
package aes128_pkg;

    typedef enum logic [2:0] {IDLE, EXPAND, READY, START, RUN, OUT} state_t;

    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Entry 0 sits in the top byte, so entry b starts at bit 2047-8*b = {~b,3'b111}.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

endpackage

// File: rtl/aes128_key_expand_step.sv
// aes128_key_expand_step: one combinational FIPS-197 key-schedule step, rk[i-1] -> rk[i].
module aes128_key_expand_step
    import aes128_pkg::*;
(
    input  logic [127:0] rk_prev,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_next
);

    logic [31:0] rot, t, n0, n1, n2, n3;

    assign rot = {rk_prev[23:0], rk_prev[31:24]};
    assign t   = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign n0  = rk_prev[127:96] ^ t;
    assign n1  = rk_prev[95:64] ^ n0;
    assign n2  = rk_prev[63:32] ^ n1;
    assign n3  = rk_prev[31:0] ^ n2;
    assign rk_next = {n0, n1, n2, n3};

endmodule

// File: rtl/aes128_decipher_ctrl.sv
// aes128_decipher_ctrl: expands an AES-128 key into a round-key store and sequences an
// external iterative decipher core, feeding it round keys in reverse order.
module aes128_decipher_ctrl
    import aes128_pkg::*;
(
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [127:0] key_in,
    output logic         key_ready,
    input  logic         ct_valid,
    input  logic [127:0] ct_data,
    output logic         ct_ready,
    output logic         pt_valid,
    output logic [127:0] pt_data,
    input  logic         pt_ready,
    output logic         busy,
    output logic         core_decipher_en,
    output logic [127:0] core_cipher_text,
    output logic [127:0] core_round_key_10,
    output logic [127:0] core_round_key_inv,
    input  logic [3:0]   core_round_num,
    input  logic         core_decipher_ready,
    input  logic [127:0] core_plain_text
);

    state_t state, state_nx;
    logic [127:0] rk [0:NUM_ROUNDS];
    logic [127:0] ct_reg, rk_nx;
    logic [3:0]   cnt;
    logic         key_accept, ct_accept;

    assign key_accept = key_load && (state inside {IDLE, EXPAND, READY});
    assign ct_accept  = ct_valid && ct_ready;

    aes128_key_expand_step u_step (
        .rk_prev (rk[cnt - 4'd1]),
        .rcon    (RCON[cnt]),
        .rk_next (rk_nx)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Key store and ciphertext register carry no reset; the FSM decides when they are valid.
    always_ff @(posedge clk_sys) begin
        if (key_accept) begin
            rk[0] <= key_in;
            cnt   <= 4'd1;
        end else if (state == EXPAND) begin
            rk[cnt] <= rk_nx;
            cnt     <= cnt + 4'd1;
        end
        if (ct_accept) ct_reg <= ct_data;
    end

    always_comb begin
        state_nx         = state;
        key_ready        = state inside {READY, START, RUN, OUT};
        ct_ready         = (state == READY) && !key_load;
        pt_valid         = state == OUT;
        busy             = state inside {EXPAND, START, RUN, OUT};
        core_decipher_en = (state == START) && core_decipher_ready;
        unique case (state)
            IDLE:    state_nx = key_load ? EXPAND : IDLE;
            EXPAND:  state_nx = (!key_load && cnt == NUM_ROUNDS) ? READY : EXPAND;
            READY:   state_nx = key_load ? EXPAND : (ct_valid ? START : READY);
            START:   state_nx = core_decipher_ready ? RUN : START;
            RUN:     state_nx = (core_round_num == NUM_ROUNDS) ? OUT : RUN;
            OUT:     state_nx = pt_ready ? READY : OUT;
            default: state_nx = IDLE;
        endcase
    end

    assign pt_data            = core_plain_text;
    assign core_cipher_text   = ct_reg;
    assign core_round_key_10  = rk[NUM_ROUNDS];
    assign core_round_key_inv = (core_round_num >= 4'd1 && core_round_num <= NUM_ROUNDS)
                              ? rk[NUM_ROUNDS - core_round_num] : rk[NUM_ROUNDS];

endmodule
